// File: rtl/rect_swap_engine.sv
// rtl/rect_swap_engine.sv - randomized 2x2 checkerboard swap engine for binary matrices
module rect_swap_engine #(
  parameter int ROW_LEN = 4,
  parameter int COL_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                instr,
  input  logic [ROW_LEN*COL_LEN-1:0] in_m,
  output logic [ROW_LEN*COL_LEN-1:0] out_m,
  output logic                       busy,
  output logic                       done,
  output logic [11:0]                swap_count
);

  localparam int RW = $clog2(ROW_LEN);
  localparam int CW = $clog2(COL_LEN);
  localparam int MW = ROW_LEN * COL_LEN;
  localparam int IW = RW + CW;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_ACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_CHECK,
    S_SWAP,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [MW-1:0]  r_m;
  logic [11:0]    r_cnt;
  logic [11:0]    r_swaps;
  logic [31:0]    r_lfsr;
  logic [RW-1:0]  r_r1;
  logic [RW-1:0]  r_r2;
  logic [CW-1:0]  r_c1;
  logic [CW-1:0]  r_c2;

  logic [31:0]    w_lfsr_next;
  logic [31:0]    w_seed;
  logic [IW-1:0]  w_i11;
  logic [IW-1:0]  w_i12;
  logic [IW-1:0]  w_i21;
  logic [IW-1:0]  w_i22;
  logic           w_valid;
  logic           w_cnt_zero;

  // Since both dimensions are powers of two, bit r*COL_LEN+c is just {r,c}.
  assign w_i11 = {r_r1, r_c1};
  assign w_i12 = {r_r1, r_c2};
  assign w_i21 = {r_r2, r_c1};
  assign w_i22 = {r_r2, r_c2};

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  // An all-zero seed would lock the LFSR, so substitute a fixed non-zero one.
  assign w_seed      = (instr[31:12] == 20'd0) ? LFSR_INIT : {12'h000, instr[31:12]};
  assign w_cnt_zero  = (r_cnt == 12'd0);

  // A swap is legal only on a 2x2 checkerboard, which keeps all line sums intact.
  assign w_valid = (r_r1 != r_r2) && (r_c1 != r_c2) &&
                   (r_m[w_i11] == r_m[w_i22]) &&
                   (r_m[w_i12] == r_m[w_i21]) &&
                   (r_m[w_i11] != r_m[w_i12]);

  assign out_m      = r_m;
  assign swap_count = r_swaps;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (instr[11:0] != 12'd0) ? S_PICK : S_DONE;
        end
      end
      S_PICK: begin
        w_next_state = S_CHECK;
      end
      S_CHECK: begin
        if (w_valid) begin
          w_next_state = S_SWAP;
        end else begin
          w_next_state = w_cnt_zero ? S_DONE : S_PICK;
        end
      end
      S_SWAP: begin
        w_next_state = w_cnt_zero ? S_DONE : S_PICK;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: load on accepted start, draw indices in PICK, flip the 2x2 in SWAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m     <= '0;
      r_cnt   <= 12'd0;
      r_swaps <= 12'd0;
      r_lfsr  <= LFSR_INIT;
      r_r1    <= '0;
      r_r2    <= '0;
      r_c1    <= '0;
      r_c2    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= in_m;
            r_cnt   <= instr[11:0];
            r_swaps <= 12'd0;
            r_lfsr  <= w_seed;
          end
        end
        S_PICK: begin
          r_r1   <= r_lfsr[RW-1:0];
          r_c1   <= r_lfsr[8+:CW];
          r_r2   <= r_lfsr[16+:RW];
          r_c2   <= r_lfsr[24+:CW];
          r_lfsr <= w_lfsr_next;
          r_cnt  <= r_cnt - 12'd1;
        end
        S_SWAP: begin
          r_m[w_i11] <= ~r_m[w_i11];
          r_m[w_i12] <= ~r_m[w_i12];
          r_m[w_i21] <= ~r_m[w_i21];
          r_m[w_i22] <= ~r_m[w_i22];
          r_swaps    <= r_swaps + 12'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/rect_swap_engine.md
RECT_SWAP_ENGINE -- requirements
Module: rect_swap_engine

Interface
REQ-001 SHALL have parameter ROW_LEN, default 4: matrix rows; power of two, 2..16.
REQ-002 SHALL have parameter COL_LEN, default 4: matrix columns; power of two, 2..16.
REQ-003 SHALL have derived widths RW = $clog2(ROW_LEN) and CW = $clog2(COL_LEN).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin a run.
REQ-007 SHALL have port instr, input, 32 bits: [11:0] attempt count N; [31:12] LFSR seed S.
REQ-008 SHALL have port in_m, input, ROW_LEN*COL_LEN bits: flat binary matrix; element (r,c) at bit r*COL_LEN+c.
REQ-009 SHALL have port out_m, output, ROW_LEN*COL_LEN bits: current internal matrix, same packing as in_m.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at run end.
REQ-012 SHALL have port swap_count, output, 12 bits: successful swaps in the current or last run.

Function
REQ-013 SHALL implement FSM states IDLE, PICK, CHECK, SWAP and DONE.
REQ-014 SHALL, in IDLE with start=1, on the same edge: load the matrix from in_m, load attempt counter with N, clear swap_count, and load the LFSR with {12'h000, S} (32'h0000_ACE1 if S==0).
REQ-015 SHALL, on that start edge, go to PICK if N!=0 and to DONE if N==0.
REQ-016 SHALL ignore start in every state other than IDLE; a held start SHALL NOT re-trigger until the FSM is back in IDLE.
REQ-017 SHALL, in PICK (one cycle), latch r1=lfsr[RW-1:0], c1=lfsr[8+:CW], r2=lfsr[16+:RW] and c2=lfsr[24+:CW].
REQ-018 SHALL, in PICK, advance the LFSR by one step, decrement the attempt counter, and go to CHECK.
REQ-019 SHALL use a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advancing only in PICK.
REQ-020 SHALL, in CHECK (one cycle), evaluate valid = (r1!=r2) & (c1!=c2) & (M[r1][c1]==M[r2][c2]) & (M[r1][c2]==M[r2][c1]) & (M[r1][c1]!=M[r1][c2]).
REQ-021 SHALL, in CHECK, go to SWAP if valid=1.
REQ-022 SHALL, in CHECK with valid=0, go to PICK if the attempt counter is non-zero and to DONE otherwise.
REQ-023 SHALL, in SWAP (one cycle), invert M[r1][c1], M[r1][c2], M[r2][c1] and M[r2][c2] simultaneously and increment swap_count.
REQ-024 SHALL, from SWAP, go to PICK if the attempt counter is non-zero and to DONE otherwise.
REQ-025 SHALL preserve every row sum and every column sum of the matrix across any swap.
REQ-026 SHALL, in DONE, drive done=1 for exactly one cycle and then go to IDLE.
REQ-027 SHALL hold out_m and swap_count stable in IDLE until the next accepted start.
REQ-028 SHALL give total run latency, start edge to done high, of 1 + 2N + (number of successful swaps) cycles; for N==0 done SHALL be high the cycle after the start edge.
REQ-029 SHALL never let swap_count exceed N; no wrap of swap_count is possible.

Reset
REQ-030 SHALL, while rst=1, force immediately and asynchronously of clk: state=IDLE, out_m=0, busy=0, done=0, swap_count=0, attempt counter=0, indices=0, LFSR=32'h0000_ACE1.
REQ-031 SHALL, on rst asserted mid-run, abandon the run with no done pulse, and SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover: in_m all zeros, N=5, S=1 -> swap_count=0, out_m unchanged, done high exactly 11 cycles after the start edge, busy high for those 11 cycles.
REQ-033 SHALL cover: N=0 with any in_m -> out_m=in_m, done pulses on the cycle after the start edge, swap_count=0.
REQ-034 SHALL cover: 4x4 permutation matrix (identity), N=4095, random S -> every row and column sum of out_m equals 1, swap_count<=4095, latency matches REQ-028 as counted from SWAP visits.
REQ-035 SHALL cover: start pulsed while busy -> no reload, run finishes unchanged, exactly one done pulse.
REQ-036 SHALL cover: rst asserted in CHECK mid-run -> out_m=0, busy=0, swap_count=0 immediately; new start after rst -> normal run with identical results to a run from a clean reset with the same instr and in_m.
REQ-037 SHALL cover: ROW_LEN=2, COL_LEN=8, random matrices and seeds, 1000 runs -> row/column sums preserved and a reference model driven by the same LFSR matches out_m bit-exactly.
